instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch/issue front end: holds PC, requests instruction words from imem over
//  a req/ready + rvalid handshake and latches them into the instruction register (IR).
//  Presents IR[31:26] as opcode to control_unit, then waits for execute to finish.
//  Takes back branch/jump/jr resolution from decode/ALU and computes the next PC.
//  Multi-cycle; exactly one instruction is in flight.
// PARAMETERS
//  ADDR_W    32   PC/imem address width; must be >= 28 (jump concat uses PC[31:28]).
//  INSTR_W   32   instruction width; opcode = instr[31:26].
//  RESET_PC  0    PC value loaded on reset.
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        synchronous, active-high
//  imem_req      out  1        fetch request valid
//  imem_addr     out  ADDR_W   fetch address (= pc)
//  imem_ready    in   1        imem accepts request this cycle
//  imem_rvalid   in   1        response word valid
//  imem_rdata    in   INSTR_W  response word
//  instr         out  INSTR_W  IR contents
//  opcode        out  6        IR[31:26], to control_unit
//  instr_valid   out  1        IR holds a live instruction for execute
//  exec_done     in   1        execute complete; resolution inputs valid
//  branch        in   1        from control_unit (beq/bne)
//  branch_cond   in   1        ALU condition met (zero for beq, !zero for bne)
//  jump          in   1        from control_unit (j/jal)
//  jr_sel        in   1        jr decoded (R-type funct)
//  jr_target     in   ADDR_W   rs value for jr
//  pc            out  ADDR_W   address of the instruction in IR
//  pc_plus4      out  ADDR_W   pc+4, link value for jal
// BEHAVIOUR
//  Reset (clock edge with reset=1): state=IDLE, pc=RESET_PC, IR=0,
//   imem_req=0, instr_valid=0. imem shares this reset and drops outstanding requests.
//  FSM states and transitions:
//   IDLE : outputs quiet; -> FETCH next cycle (first req one cycle after reset drops).
//   FETCH: imem_req=1, imem_addr=pc; on imem_ready -> WAIT. rvalid ignored here.
//   WAIT : imem_req=0; on imem_rvalid capture IR<=imem_rdata -> ISSUE.
//          Earliest response is the cycle after acceptance (latency >= 1).
//   ISSUE: instr_valid=1, IR/opcode stable; on exec_done update pc -> FETCH.
//  exec_done outside ISSUE is ignored. Minimum 3 cycles per instruction
//   (ready=1, rvalid next cycle, exec_done same cycle as issue).
//  opcode/instr hold their last value while instr_valid=0. Datapath must gate writes
//   with instr_valid (reset IR=0 decodes as R-type).
//  Next-PC priority, sampled on exec_done: jr_sel > jump > (branch & branch_cond) > pc+4.
//   jr     : {jr_target[ADDR_W-1:2], 2'b00}; low bits forced to 0
//   jump   : {pc_plus4[ADDR_W-1:28], IR[25:0], 2'b00}
//   branch : pc_plus4 + (sext(IR[15:0]) << 2)
//   branch=1 with branch_cond=0 falls through to pc+4.
//  All PC arithmetic is modulo 2^ADDR_W (0x...FFFC + 4 wraps to 0).
//  Reset in any state overrides everything in that cycle and returns to IDLE.
//   No stale response may be captured afterwards.
// STRUCTURE
//  cpu_pkg: OP_BEQ=6'b100011, OP_BNE=6'b100111, OP_J=6'b111000,
//   OP_JAL=6'b111001, OP_RTYPE=6'b000000, fetch-state encodings, INSTR_W.
//  Sub-module next_pc_logic (combinational): pc, IR, branch/cond/jump/jr inputs
//   -> next_pc and pc_plus4. FSM and registers stay in instr_fetch_unit.
// TESTING
//  1 reset 3 cycles, ready=1, rvalid next cycle -> IDLE 1 cycle, then imem_req=1 at
//    addr 0x0; instr_valid=1 two cycles later.
//  2 IR=0x8C22_0003 (beq, imm=3), branch=1, cond=1, pc=0x10, exec_done -> next req 0x20.
//    Same instruction with cond=0 -> next req 0x14.
//  3 IR=0xE000_0040 (j), jump=1, pc=0x100 -> next req 0x100.
//    jr_sel=1 with jump=1 and jr_target=0x207 -> next req 0x204 (jr wins).
//  4 Backpressure: ready=0 for 5 cycles, then rvalid 4 cycles after acceptance ->
//    req/addr held stable, IR captured only on rvalid, opcode unchanged meanwhile.
//  5 reset asserted in WAIT, then a spurious rvalid in FETCH -> IR stays 0.
//    PC restarts at RESET_PC.
//  6 pc=0xFFFF_FFFC, plain op, exec_done -> next req 0x0; pc_plus4 reads 0x0 in ISSUE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcodes, instruction width and
// the fetch sequencer state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_logic #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [25:0]       instr_idx_i,
  input  logic              branch_i,
  input  logic              branch_cond_i,
  input  logic              jump_i,
  input  logic              jr_sel_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  // Upper region bits kept from pc+4 by a j/jal (everything above bit 27).
  localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << 28;

  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] jmp_low_s;

  // Sequential address, branch displacement and jump index expansion.
  always_comb begin
    pc_plus4_s = pc_i + {{(ADDR_W-3){1'b0}}, 3'd4};
    br_off_s   = {{(ADDR_W-18){instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    jmp_low_s  = {{(ADDR_W-28){1'b0}}, instr_idx_i, 2'b00};
  end

  // Prioritised next-PC mux; jr target is forced word aligned.
  always_comb begin
    next_pc_o = pc_plus4_s;
    if (jr_sel_i) begin
      next_pc_o = jr_target_i & {{(ADDR_W-2){1'b1}}, 2'b00};
    end else if (jump_i) begin
      next_pc_o = (pc_plus4_s & HI_MASK) | jmp_low_s;
    end else if (branch_i && branch_cond_i) begin
      next_pc_o = pc_plus4_s + br_off_s;
    end else begin
      next_pc_o = pc_plus4_s;
    end
  end

  assign pc_plus4_o = pc_plus4_s;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end: one instruction in flight. Requests a word at pc,
// latches the response into IR, holds it for execute, then advances pc from
// the branch/jump/jr resolution presented with exec_done.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch,
  input  logic               branch_cond,
  input  logic               jump,
  input  logic               jr_sel,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4
);
  import cpu_pkg::*;

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               req_q;
  logic               valid_q;
  logic [ADDR_W-1:0]  next_pc_d;
  logic [ADDR_W-1:0]  pc_plus4_s;

  next_pc_logic #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i          (pc_q),
    .instr_idx_i   (ir_q[25:0]),
    .branch_i      (branch),
    .branch_cond_i (branch_cond),
    .jump_i        (jump),
    .jr_sel_i      (jr_sel),
    .jr_target_i   (jr_target),
    .next_pc_o     (next_pc_d),
    .pc_plus4_o    (pc_plus4_s)
  );

  // Fetch sequencer with registered req/valid; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= {INSTR_W{1'b0}};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            state_q <= ST_WAIT;
            req_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_q    <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            pc_q    <= next_pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = ir_q;
  assign opcode      = ir_q[INSTR_W-1:INSTR_W-6];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;

endmodule
